// File: rtl/data_mem_stage.sv
// MEM pipeline stage: single-port data RAM with byte/half/word stores, 2-edge
// extended loads, misalignment rejection and an upstream stall request.
module data_mem_stage #(
    parameter int unsigned DEPTH_WORDS = 1024
) (
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [31:0] Address,
    input  logic [31:0] WriteData,
    input  logic [1:0]  Size,
    input  logic        LoadUnsigned,
    output logic [31:0] ReadData,
    output logic        ReadValid,
    output logic        Stall,
    output logic        AccessErr
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic {
        IDLE      = 1'b0,
        LOAD_WAIT = 1'b1
    } state_e;

    state_e        state_q, state_d;
    logic [31:0]   mem [DEPTH_WORDS];
    logic [AW-1:0] idx;
    logic [31:0]   ram_rdata_q;
    logic [31:0]   rdata_q, rdata_d;
    logic          rvalid_q, rvalid_d;
    logic          err_q, err_d;
    logic [1:0]    lane_q, lane_d;
    logic [1:0]    size_q, size_d;
    logic          lu_q, lu_d;
    logic          misaligned;
    logic          ram_we, ram_re, stall_c;
    logic [3:0]    be;
    logic [31:0]   wdata_rep, rd_shift, load_ext;
    logic          unused_addr_hi;

    // Upper address bits wrap onto the RAM.
    assign idx            = Address[AW+1:2];
    assign unused_addr_hi = ^Address[31:AW+2];

    always_comb begin
        case (Size)
            SZ_BYTE: misaligned = 1'b0;
            SZ_HALF: misaligned = Address[0];
            SZ_WORD: misaligned = (Address[1:0] != 2'b00);
            default: misaligned = 1'b1;
        endcase
    end

    // Replicate store data across lanes; byte enables select the target lane(s).
    always_comb begin
        be        = 4'b0000;
        wdata_rep = WriteData;
        case (Size)
            SZ_BYTE: begin
                be        = 4'b0001 << Address[1:0];
                wdata_rep = {4{WriteData[7:0]}};
            end
            SZ_HALF: begin
                be        = Address[1] ? 4'b1100 : 4'b0011;
                wdata_rep = {2{WriteData[15:0]}};
            end
            SZ_WORD: be = 4'b1111;
            default: be = 4'b0000;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (ram_we) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) begin
                    mem[idx][8*b +: 8] <= wdata_rep[8*b +: 8];
                end
            end
        end
        if (ram_re) begin
            ram_rdata_q <= mem[idx];
        end
    end

    // Lane extraction and extension use the fields latched at acceptance.
    assign rd_shift = ram_rdata_q >> {lane_q, 3'b000};

    always_comb begin
        case (size_q)
            SZ_BYTE: load_ext = lu_q ? {24'h0, rd_shift[7:0]}
                                     : {{24{rd_shift[7]}}, rd_shift[7:0]};
            SZ_HALF: load_ext = lu_q ? {16'h0, rd_shift[15:0]}
                                     : {{16{rd_shift[15]}}, rd_shift[15:0]};
            default: load_ext = ram_rdata_q;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        rdata_d  = rdata_q;
        rvalid_d = 1'b0;
        err_d    = 1'b0;
        lane_d   = lane_q;
        size_d   = size_q;
        lu_d     = lu_q;
        ram_we   = 1'b0;
        ram_re   = 1'b0;
        stall_c  = 1'b0;
        case (state_q)
            IDLE: begin
                if (MemRead || MemWrite) begin
                    if ((MemRead && MemWrite) || misaligned) begin
                        err_d = 1'b1;
                    end else if (MemWrite) begin
                        ram_we = 1'b1;
                    end else begin
                        ram_re  = 1'b1;
                        stall_c = 1'b1;
                        lane_d  = Address[1:0];
                        size_d  = Size;
                        lu_d    = LoadUnsigned;
                        state_d = LOAD_WAIT;
                    end
                end
            end
            LOAD_WAIT: begin
                stall_c  = 1'b1;
                rdata_d  = load_ext;
                rvalid_d = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q  <= IDLE;
            rdata_q  <= 32'h0;
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
            lane_q   <= 2'b00;
            size_q   <= 2'b00;
            lu_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
            err_q    <= err_d;
            lane_q   <= lane_d;
            size_q   <= size_d;
            lu_q     <= lu_d;
        end
    end

    assign ReadData  = rdata_q;
    assign ReadValid = rvalid_q;
    assign AccessErr = err_q;
    assign Stall     = stall_c;

endmodule

// File: tb/tb_data_mem_stage.sv
// Self-checking bench for data_mem_stage: byte-array memory model, per-cycle
// output comparison, directed scenarios and randomized traffic.
module tb_data_mem_stage;

    localparam int unsigned DEPTH  = 1024;
    localparam int unsigned NBYTES = DEPTH * 4;

    logic        Clk, Rst_n, MemRead, MemWrite, LoadUnsigned;
    logic [31:0] Address, WriteData, ReadData;
    logic [1:0]  Size;
    logic        ReadValid, Stall, AccessErr;

    data_mem_stage #(.DEPTH_WORDS(DEPTH)) dut (
        .Clk          (Clk),
        .Rst_n        (Rst_n),
        .MemRead      (MemRead),
        .MemWrite     (MemWrite),
        .Address      (Address),
        .WriteData    (WriteData),
        .Size         (Size),
        .LoadUnsigned (LoadUnsigned),
        .ReadData     (ReadData),
        .ReadValid    (ReadValid),
        .Stall        (Stall),
        .AccessErr    (AccessErr)
    );

    logic [7:0]  mbytes [NBYTES];
    int          n_checks = 0;
    int          n_errors = 0;
    int          stall_cycles = 0;
    logic        chk_en = 1'b0;
    logic        exp_stall, exp_valid, exp_err;
    logic [31:0] exp_rdata;
    logic        nxt_valid, nxt_err;
    logic [31:0] nxt_rdata;

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, got, want, $time);
        end
    endtask

    function automatic logic is_misaligned(input logic [31:0] a, input logic [1:0] sz);
        return (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0);
    endfunction

    function automatic int nbytes_of(input logic [1:0] sz);
        return 1 << sz;
    endfunction

    task automatic model_store(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] wd);
        int base;
        base = int'(a % NBYTES);
        for (int k = 0; k < nbytes_of(sz); k++) mbytes[base + k] = wd[8*k +: 8];
    endtask

    function automatic logic [31:0] model_load(input logic [31:0] a, input logic [1:0] sz, input logic lu);
        int          base;
        int          n;
        logic [31:0] v;
        base = int'(a % NBYTES);
        n    = nbytes_of(sz);
        v    = 32'h0;
        for (int k = 0; k < n; k++) v = v | (32'(mbytes[base + k]) << (8 * k));
        if (n < 4 && !lu && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
        return v;
    endfunction

    // Per-cycle comparison against the model's expectations.
    always @(negedge Clk) begin
        if (chk_en) begin
            if (Stall) stall_cycles++;
            check("stall", 32'(Stall), 32'(exp_stall));
            check("read_valid", 32'(ReadValid), 32'(exp_valid));
            check("access_err", 32'(AccessErr), 32'(exp_err));
            check("read_data", ReadData, exp_rdata);
        end
    end

    task automatic begin_cycle();
        @(posedge Clk);
        #1;
        exp_valid = nxt_valid;
        exp_err   = nxt_err;
        if (nxt_valid) exp_rdata = nxt_rdata;
        nxt_valid = 1'b0;
        nxt_err   = 1'b0;
    endtask

    task automatic drive(input logic rd, input logic wr, input logic [31:0] a,
                         input logic [1:0] sz, input logic lu, input logic [31:0] wd);
        MemRead      = rd;
        MemWrite     = wr;
        Address      = a;
        Size         = sz;
        LoadUnsigned = lu;
        WriteData    = wd;
    endtask

    // One request; a load also consumes its wait cycle with junk inputs.
    task automatic op(input logic rd, input logic wr, input logic [31:0] a,
                      input logic [1:0] sz, input logic lu, input logic [31:0] wd);
        logic [31:0] ld_val;
        begin_cycle();
        drive(rd, wr, a, sz, lu, wd);
        exp_stall = 1'b0;
        if (rd || wr) begin
            if ((rd && wr) || is_misaligned(a, sz)) begin
                nxt_err = 1'b1;
            end else if (wr) begin
                model_store(a, sz, wd);
            end else begin
                exp_stall = 1'b1;
                ld_val    = model_load(a, sz, lu);
                begin_cycle();
                drive(1'($urandom), 1'($urandom), $urandom, 2'($urandom), 1'($urandom), $urandom);
                exp_stall = 1'b1;
                nxt_valid = 1'b1;
                nxt_rdata = ld_val;
            end
        end
    endtask

    task automatic idle();
        op(1'b0, 1'b0, 32'h0, 2'd0, 1'b0, 32'h0);
    endtask

    task automatic load_lit(input string name, input logic [31:0] a, input logic [1:0] sz,
                            input logic lu, input logic [31:0] want);
        stall_cycles = 0;
        op(1'b1, 1'b0, a, sz, lu, 32'h0);
        idle();
        @(negedge Clk);
        #1;
        check({name, "_stall_cycles"}, 32'(stall_cycles), 32'd2);
        check({name, "_valid"}, 32'(ReadValid), 32'd1);
        check(name, ReadData, want);
    endtask

    task automatic err_lit(input string name, input logic rd, input logic wr, input logic [31:0] a,
                           input logic [1:0] sz, input logic [31:0] wd);
        op(rd, wr, a, sz, 1'b0, wd);
        @(negedge Clk);
        #1;
        check({name, "_stall"}, 32'(Stall), 32'd0);
        idle();
        @(negedge Clk);
        #1;
        check({name, "_err"}, 32'(AccessErr), 32'd1);
        check({name, "_no_valid"}, 32'(ReadValid), 32'd0);
    endtask

    task automatic random_ops(input int count);
        int          kind;
        logic [31:0] a;
        logic [1:0]  sz;
        for (int i = 0; i < count; i++) begin
            kind = int'($urandom_range(0, 9));
            sz   = 2'($urandom_range(0, 3));
            a    = $urandom & 32'hFFFF_F0FF;
            if ($urandom_range(0, 3) != 0) begin
                if (sz == 2'd1) a[0] = 1'b0;
                else if (sz == 2'd2) a[1:0] = 2'b00;
            end
            if (kind <= 3)      op(1'b0, 1'b1, a, sz, 1'($urandom), $urandom);
            else if (kind <= 7) op(1'b1, 1'b0, a, sz, 1'($urandom), $urandom);
            else if (kind == 8) op(1'b1, 1'b1, a, sz, 1'($urandom), $urandom);
            else                idle();
        end
    endtask

    initial begin
        Rst_n = 1'b0;
        drive(1'b0, 1'b0, 32'h0, 2'd0, 1'b0, 32'h0);
        exp_stall = 1'b0;
        exp_valid = 1'b0;
        exp_err   = 1'b0;
        exp_rdata = 32'h0;
        nxt_valid = 1'b0;
        nxt_err   = 1'b0;
        nxt_rdata = 32'h0;
        for (int i = 0; i < int'(NBYTES); i++) mbytes[i] = 8'h0;
        chk_en = 1'b1;

        @(negedge Clk);
        #1;
        check("reset_rdata", ReadData, 32'h0);
        check("reset_valid", 32'(ReadValid), 32'd0);
        check("reset_err", 32'(AccessErr), 32'd0);
        check("reset_stall", 32'(Stall), 32'd0);
        begin_cycle();
        Rst_n = 1'b1;

        for (int w = 0; w < int'(DEPTH); w++) op(1'b0, 1'b1, 32'(w * 4), 2'd2, 1'b0, 32'h0);

        op(1'b0, 1'b1, 32'h10, 2'd2, 1'b0, 32'hDEADBEEF);
        load_lit("word_ld", 32'h10, 2'd2, 1'b0, 32'hDEADBEEF);

        op(1'b0, 1'b1, 32'h13, 2'd0, 1'b0, 32'h80);
        load_lit("byte_signed", 32'h13, 2'd0, 1'b0, 32'hFFFFFF80);
        load_lit("byte_unsigned", 32'h13, 2'd0, 1'b1, 32'h00000080);
        load_lit("word_merged", 32'h10, 2'd2, 1'b0, 32'h80ADBEEF);
        load_lit("half_hi_signed", 32'h12, 2'd1, 1'b0, 32'hFFFF80AD);
        load_lit("half_lo_unsigned", 32'h10, 2'd1, 1'b1, 32'h0000BEEF);

        op(1'b0, 1'b1, 32'h20, 2'd2, 1'b0, 32'hCAFEF00D);
        err_lit("mis_half_ld", 1'b1, 1'b0, 32'h21, 2'd1, 32'h0);
        err_lit("mis_word_st", 1'b0, 1'b1, 32'h22, 2'd2, 32'h11111111);
        load_lit("mis_unchanged", 32'h20, 2'd2, 1'b0, 32'hCAFEF00D);
        err_lit("rsv_size", 1'b1, 1'b0, 32'h10, 2'd3, 32'h0);
        err_lit("rd_and_wr", 1'b1, 1'b1, 32'h20, 2'd2, 32'h55555555);
        load_lit("rdwr_unchanged", 32'h20, 2'd2, 1'b0, 32'hCAFEF00D);

        op(1'b0, 1'b1, 32'h1000, 2'd2, 1'b0, 32'h12345678);
        load_lit("wrap", 32'h0, 2'd2, 1'b0, 32'h12345678);

        // Reset asserted while the load is in its wait cycle.
        begin_cycle();
        drive(1'b1, 1'b0, 32'h10, 2'd2, 1'b0, 32'h0);
        exp_stall = 1'b1;
        begin_cycle();
        drive(1'b0, 1'b0, 32'h0, 2'd0, 1'b0, 32'h0);
        Rst_n     = 1'b0;
        exp_stall = 1'b0;
        exp_valid = 1'b0;
        exp_err   = 1'b0;
        exp_rdata = 32'h0;
        @(negedge Clk);
        #1;
        check("midload_rst_rdata", ReadData, 32'h0);
        check("midload_rst_valid", 32'(ReadValid), 32'd0);
        repeat (2) begin_cycle();
        check("rst_hold_valid", 32'(ReadValid), 32'd0);
        begin_cycle();
        Rst_n = 1'b1;
        idle();
        load_lit("post_rst", 32'h10, 2'd2, 1'b0, 32'h80ADBEEF);

        random_ops(3000);
        repeat (3) idle();
        @(negedge Clk);
        #1;
        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
